// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding and
// load-use hazard detection.
// Optional feature macro: ID_EX_FWD_EN
//   defined   -> EX/MEM and MEM/WB results are forwarded into the EX operands;
//                only load-use stalls.
//   undefined -> operands come straight from the register file; any RAW
//                against EX or EX/MEM stalls until the value reaches the RF.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_control,
    input  logic [3:0]  id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [3:0]  ex_alu_control,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_ctrl,
    output logic        hazard_stall
);

    // ctrl bit positions: {alu_src, reg_write, mem_read, mem_write}
    localparam int ALU_SRC   = 3;
    localparam int REG_WRITE = 2;
    localparam int MEM_READ  = 1;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_control;
        logic [3:0]  ctrl;
    } idex_t;

    idex_t r;

    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic        id_hits_ex;
    logic        load_use;

    // ID source matches the destination of the valid instruction now in EX
    assign id_hits_ex = id_valid && r.valid && (r.rd != 5'd0) &&
                        ((r.rd == id_rs1) || (r.rd == id_rs2));
    assign load_use   = id_hits_ex && r.ctrl[MEM_READ];

`ifdef ID_EX_FWD_EN
    // EX/MEM is younger than MEM/WB, so it wins on a double match
    assign fwd_rs1 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r.rs1) ? exmem_result :
                     (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r.rs1) ? memwb_result :
                     r.rs1_data;
    assign fwd_rs2 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r.rs2) ? exmem_result :
                     (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r.rs2) ? memwb_result :
                     r.rs2_data;
    assign hazard_stall = load_use;
`else
    logic id_hits_exmem;
    logic unused_fwd;

    // No bypass network: hold ID until the producer has left EX/MEM; the
    // write-before-read register file covers the MEM/WB distance.
    assign id_hits_exmem = id_valid && exmem_reg_write && (exmem_rd != 5'd0) &&
                           ((exmem_rd == id_rs1) || (exmem_rd == id_rs2));
    assign fwd_rs1       = r.rs1_data;
    assign fwd_rs2       = r.rs2_data;
    assign hazard_stall  = load_use || (id_hits_ex && r.ctrl[REG_WRITE]) || id_hits_exmem;
    assign unused_fwd    = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, r.rs1, r.rs2};
`endif

    // Stage register: rst > flush > stall hold > hazard bubble > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (flush) begin
            r <= '0;
        end else if (stall) begin
            r <= r;
        end else if (hazard_stall || !id_valid) begin
            r <= '0;
        end else begin
            r.valid       <= 1'b1;
            r.rs1         <= id_rs1;
            r.rs2         <= id_rs2;
            r.rd          <= id_rd;
            r.rs1_data    <= id_rs1_data;
            r.rs2_data    <= id_rs2_data;
            r.imm         <= id_imm;
            r.alu_control <= id_alu_control;
            r.ctrl        <= id_ctrl;
        end
    end

    assign ex_valid       = r.valid;
    assign ex_in1         = fwd_rs1;
    assign ex_in2         = r.ctrl[ALU_SRC] ? r.imm : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_alu_control = r.alu_control;
    assign ex_rd          = r.rd;
    assign ex_ctrl        = r.ctrl[2:0] & {3{r.valid}};

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage. Each record drives one
// cycle of inputs and names the hazard_stall it must produce; a reference
// model pushes the expected EX contents to a scoreboard queue, which is popped
// and compared on the following cycle against the ex_* outputs.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit NOFWD = 1'b0;
`else
    localparam bit NOFWD = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_control, id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, hazard_stall;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_ctrl;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, stall, flush, v;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit [3:0]  alu, ctrl;
        bit        xw;  bit [4:0] xrd; bit [31:0] xres;
        bit        ww;  bit [4:0] wrd; bit [31:0] wres;
        bit        exp_hz;
    } vec_t;

    // Expected EX contents; zr marks a state produced by reset (data must be 0)
    typedef struct {
        bit        v;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit [3:0]  alu, ctrl;
        bit        zr;
    } st_t;

    st_t sb[$];

    localparam bit [3:0] ADD = 4'b0010, SUB = 4'b0110;
    localparam bit [3:0] C_R = 4'b0100, C_I = 4'b1100, C_LD = 4'b1110;

    function automatic vec_t ins(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                                 bit [31:0] d1, bit [31:0] d2, bit [31:0] imm,
                                 bit [3:0] alu, bit [3:0] ctrl, bit hz);
        vec_t t;
        t = '{default: 0};
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.d1 = d1; t.d2 = d2; t.imm = imm; t.alu = alu; t.ctrl = ctrl;
        t.exp_hz = hz;
        return t;
    endfunction

    // Value the EX stage should see for a source, given the bypass inputs now on the bus
    function automatic bit [31:0] m_fwd(bit [4:0] rs, bit [31:0] d);
`ifdef ID_EX_FWD_EN
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
`endif
        return d;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(int idx, vec_t t);
        st_t m, n;
        @(negedge clk);
        rst = t.rst; stall = t.stall; flush = t.flush; id_valid = t.v;
        id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_rs1_data = t.d1; id_rs2_data = t.d2; id_imm = t.imm;
        id_alu_control = t.alu; id_ctrl = t.ctrl;
        exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
        memwb_reg_write = t.ww; memwb_rd = t.wrd; memwb_result = t.wres;
        #1;
        m = '{default: 0};
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk($sformatf("hazard_stall s%0d", idx), 32'(hazard_stall), 32'(t.exp_hz));
            chk($sformatf("ex_valid s%0d", idx), 32'(ex_valid), 32'(m.v));
            chk($sformatf("ex_ctrl s%0d", idx), 32'(ex_ctrl), m.v ? 32'(m.ctrl[2:0]) : 32'd0);
            chk($sformatf("ex_rd s%0d", idx), 32'(ex_rd), 32'(m.rd));
            chk($sformatf("ex_alu_control s%0d", idx), 32'(ex_alu_control), 32'(m.alu));
            if (m.v || m.zr) begin
                chk($sformatf("ex_in1 s%0d", idx), ex_in1, m_fwd(m.rs1, m.d1));
                chk($sformatf("ex_in2 s%0d", idx), ex_in2, m.ctrl[3] ? m.imm : m_fwd(m.rs2, m.d2));
                chk($sformatf("ex_store_data s%0d", idx), ex_store_data, m_fwd(m.rs2, m.d2));
            end
        end
        // Next EX contents, from the recorded hazard rather than a recomputed one
        n = '{default: 0};
        if (t.rst) n.zr = 1'b1;
        else if (t.flush) n.zr = 1'b0;
        else if (t.stall) n = m;
        else if (t.exp_hz || !t.v) n.zr = 1'b0;
        else begin
            n.v = 1'b1; n.rs1 = t.rs1; n.rs2 = t.rs2; n.rd = t.rd;
            n.d1 = t.d1; n.d2 = t.d2; n.imm = t.imm; n.alu = t.alu; n.ctrl = t.ctrl;
        end
        sb.push_back(n);
    endtask

    vec_t tbl[25];

    initial begin
        tbl[0]  = ins(1, 1, 2, 3, 32'h1, 32'h2, 0, ADD, C_R, 0);
        tbl[0].rst = 1; tbl[0].stall = 1;
        tbl[1]  = ins(1, 1, 2, 5, 3, 4, 0, ADD, C_R, 0);
        tbl[2]  = ins(1, 3, 4, 6, 4, 5, 0, ADD, C_R, 0);
        // reader of x5 with a stale RF value; EX/MEM supplies 16 next cycle
        tbl[3]  = ins(1, 5, 0, 7, 100, 0, 0, ADD, C_R, 0);
        tbl[4]  = ins(1, 3, 9, 10, 32'h33, 2, 0, ADD, C_R, 0);
        tbl[4].xw = 1; tbl[4].xrd = 5; tbl[4].xres = 16;
        // dual match on x3: EX/MEM 0xA beats MEM/WB 0xB
        tbl[5]  = ins(1, 0, 12, 13, 32'h55, 3, 0, ADD, C_R, 0);
        tbl[5].xw = 1; tbl[5].xrd = 3; tbl[5].xres = 32'hA;
        tbl[5].ww = 1; tbl[5].wrd = 3; tbl[5].wres = 32'hB;
        // rd=0 in both stages never forwards
        tbl[6]  = ins(1, 14, 15, 16, 1, 5, 32'hFFFF_FFFC, ADD, C_I, 0);
        tbl[6].xw = 1; tbl[6].xrd = 0; tbl[6].xres = 32'hA;
        tbl[6].ww = 1; tbl[6].wrd = 0; tbl[6].wres = 32'hB;
        tbl[7]  = ins(1, 1, 0, 4, 32'h100, 0, 8, ADD, C_LD, 0);
        // load-use on x4
        tbl[8]  = ins(1, 4, 2, 17, 32'h44, 6, 0, ADD, C_R, 1);
        tbl[9]  = ins(1, 4, 2, 17, 32'h44, 6, 0, ADD, C_R, 0);
        tbl[10] = ins(1, 20, 21, 22, 7, 8, 0, SUB, C_R, 0);
        // three stall cycles holding H; RAW on x22 only stalls without bypass
        tbl[11] = ins(1, 22, 0, 23, 9, 9, 0, ADD, C_R, NOFWD);
        tbl[11].stall = 1;
        tbl[12] = tbl[11];
        tbl[13] = ins(1, 0, 0, 1, 5, 0, 0, ADD, C_R, 0);
        tbl[13].stall = 1;
        tbl[14] = ins(1, 0, 0, 1, 5, 0, 0, ADD, C_R, 0);
        tbl[15] = ins(1, 0, 0, 2, 1, 1, 0, ADD, C_R, 0);
        tbl[15].stall = 1; tbl[15].flush = 1;
        tbl[16] = ins(1, 0, 0, 9, 32'h200, 0, 0, ADD, C_LD, 0);
        // flush together with a load-use hazard
        tbl[17] = ins(1, 9, 0, 10, 1, 1, 0, ADD, C_R, 1);
        tbl[17].flush = 1;
        tbl[18] = ins(1, 0, 0, 2, 9, 0, 0, ADD, C_R, 0);
        tbl[19] = ins(0, 2, 0, 3, 1, 1, 0, ADD, C_R, 0);
        tbl[20] = ins(1, 0, 0, 4, 32'h300, 0, 4, ADD, C_LD, 0);
        // reset while stalled with a live load-use hazard
        tbl[21] = ins(1, 4, 0, 5, 1, 1, 0, ADD, C_R, 1);
        tbl[21].rst = 1; tbl[21].stall = 1;
        tbl[22] = ins(1, 6, 7, 8, 32'h11, 32'h22, 0, SUB, C_R, 0);
        tbl[23] = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) step(i, tbl[i]);

        // Hand-checked spot values for the key scenarios
        // (state after tbl[24] is a bubble; re-run a short sequence by hand)
        step(100, tbl[0]);
        step(101, tbl[3]);
        step(102, tbl[4]);
        chk("fwd x5 value", ex_in1, NOFWD ? 32'd100 : 32'd16);
        step(103, tbl[5]);
        chk("dual match value", ex_in1, NOFWD ? 32'h33 : 32'hA);
        step(104, tbl[6]);
        chk("rd0 no forward", ex_in1, 32'h55);
        step(105, tbl[7]);
        chk("itype in2", ex_in2, 32'hFFFF_FFFC);
        chk("itype store", ex_store_data, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
